// File: rtl/rrc_rx_decimator_if.sv
// Sample-in / symbol-out bundle for rrc_rx_decimator.
// master drives samples and the phase strobe; slave is the filter.
interface rrc_rx_decimator_if #(parameter int WIDTH = 9);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    phase_clr;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_bit;

  modport master (
    output in_valid, in_data, phase_clr,
    input  in_ready, out_valid, out_data, out_bit
  );

  modport slave (
    input  in_valid, in_data, phase_clr,
    output in_ready, out_valid, out_data, out_bit
  );
endinterface

// File: rtl/rrc_rx_decimator.sv
// 33-tap RRC matched filter + decimator using one time-multiplexed MAC.
// Optional macro RRC_RX_ROUND_EN: round half up instead of floor before saturation.
module rrc_rx_decimator #(
  parameter int WIDTH = 9,
  parameter int DECIM = 4,
  parameter int ACC_W = 24
) (
  input logic              clk,
  input logic              rst,
  rrc_rx_decimator_if.slave bus
);

  localparam int TAPS   = 33;
  localparam int P_W    = $clog2(DECIM);
  localparam int PROD_W = 2 * WIDTH;
  localparam logic [5:0] LAST_K = 6'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-256);

  localparam logic signed [8:0] COEF [0:TAPS-1] = '{
    9'sd0,   -9'sd1,   9'sd1,   9'sd0,  -9'sd1,   9'sd2,  9'sd0,  -9'sd2,
    9'sd2,    9'sd0,  -9'sd6,   9'sd8,   9'sd10, -9'sd28, -9'sd14, 9'sd111,
    9'sd196,  9'sd111, -9'sd14, -9'sd28, 9'sd10,  9'sd8,  -9'sd6,  9'sd0,
    9'sd2,   -9'sd2,   9'sd0,   9'sd2,  -9'sd1,   9'sd0,  9'sd1,  -9'sd1,
    9'sd0
  };

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic signed [WIDTH-1:0] d [0:TAPS-1];
  logic [P_W-1:0]          p;
  logic [5:0]              k;
  logic signed [ACC_W-1:0] acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_adj;
  logic signed [ACC_W-1:0] shifted;
  logic signed [WIDTH-1:0] result;
  logic                    xfer;
  logic                    dec_point;

  assign bus.in_ready = (state == IDLE);
  assign xfer         = bus.in_valid && (state == IDLE);
  // A sample tagged with phase_clr is phase 0, so it can never be a decimation point.
  assign dec_point    = xfer && !bus.phase_clr && (p == P_W'(DECIM - 1));

  assign prod     = COEF[k] * d[k];
  assign prod_ext = ACC_W'(prod);

`ifdef RRC_RX_ROUND_EN
  assign acc_adj = acc + ACC_W'(128);
`else
  assign acc_adj = acc;
`endif

  assign shifted = acc_adj >>> 8;

  always_comb begin
    result = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dec_point) state_next = MAC;
      MAC:     if (k == LAST_K) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
      p             <= '0;
      k             <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_bit   <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;

      if (xfer) begin
        d[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
      end

      if (bus.phase_clr) begin
        p <= xfer ? P_W'(1) : '0;
      end else if (xfer) begin
        p <= (p == P_W'(DECIM - 1)) ? '0 : p + P_W'(1);
      end

      case (state)
        MAC: begin
          acc <= (k == 6'd0) ? prod_ext : acc + prod_ext;
          k   <= (k == LAST_K) ? 6'd0 : k + 6'd1;
        end
        OUT: begin
          bus.out_data  <= result;
          bus.out_bit   <= ~result[WIDTH-1];
          bus.out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
